fpro_timer_core: RTL and testbench
==================================

// Module: fpro_timer_core
// PURPOSE
//  Free-running up-counter timer core occupying one FPro MMIO slot, downstream of the
//  MCS-to-FPro bridge and the MMIO slot decoder. Consumes the slot's cs/read/write/addr/
//  wr_data strobes and returns rd_data. Provides a coherent wide count read via a
//  high-word shadow latch, plus optional compare-match interrupt with periodic reload.
// PARAMETERS
//  CNT_W   48   counter width in bits; legal range 33..64
// PORTS
//  clk      in   1    system clock; all state updates on rising edge
//  reset    in   1    asynchronous, active-high reset
//  cs       in   1    slot select from MMIO decoder
//  read     in   1    read strobe, qualified by cs
//  write    in   1    write strobe, qualified by cs
//  addr     in   5    register index within slot
//  wr_data  in   32   write data
//  rd_data  out  32   read data, combinational from addr
//  irq      out  1    compare-match interrupt level (0 when TIMER_CMP_EN absent)
// BEHAVIOUR
//  Register map (word index): 0 CNT_LO (RO), 1 CNT_HI (RO, shadow), 2 CTRL (RW),
//   3 CMP_LO (RW), 4 CMP_HI (RW), 5 STATUS (R/W1C); 6..31 read 0, writes ignored.
//  CTRL: bit0 go, bit1 clear (write-only pulse, reads 0), bit2 reload; bits 31:3 read 0.
//  Reset: count=0, go=0, reload=0, shadow=0, cmp=all ones, irq_flag=0; rd_data follows addr.
//  wr_en = cs & write; rd_en = cs & read. Strobes without cs have no effect.
//  Counter: each cycle with go=1, count <= count+1; wraps 2^CNT_W-1 -> 0, no flag.
//  Clear: write CTRL with bit1=1 -> count=0 on that edge, overriding increment and reload;
//   go/reload take new wr_data[0]/[2] on the same edge.
//  CTRL write with go=0 freezes count at current value next cycle onward.
//  rd_data is a pure combinational mux: addr 0 -> count[31:0] (current value);
//   addr 1 -> shadow zero-extended to 32 bits; addr 2 -> {29'b0,reload,1'b0,go}.
//  Shadow: on rd_en with addr 0, shadow <= count[CNT_W-1:32] at that edge
//   (value concurrent with the CNT_LO data returned). Read addr 1 never updates shadow.
//  Read side effects only on shadow; read of STATUS does not clear it.
//  Mid-operation reset: all state returns to reset values immediately (async).
// CONFIGURATION
//  Macro TIMER_CMP_EN.
//  Defined: cmp register (CNT_W bits) split across CMP_LO/CMP_HI (HI holds bits CNT_W-1:32,
//   upper unused bits ignored on write, read 0). Match = go & (count == cmp).
//   On match: irq_flag <= 1; if reload=1, count <= 0 on that edge instead of incrementing.
//   Clear write has priority over reload. STATUS bit0 = irq_flag; writing 1 to bit0
//   clears it; simultaneous match and W1C -> flag stays 1 (set wins). irq = irq_flag.
//  Not defined: no cmp storage; addr 3..5 read 0 and ignore writes; irq tied 0;
//   reload bit still stored and readable but has no effect.
// TESTING
//  1 Reset, write CTRL=0x1, wait 10 cycles, read addr0 -> value 10 +/-1 per bench
//    strobe alignment; irq=0.
//  2 Force count to 0x0000_FFFF_FFFF (CNT_W=48), read addr0 -> 0xFFFFFFFF then addr1
//    -> 0x0000 even though count has since incremented; re-read addr0 then addr1 -> 0x0001.
//  3 Count running at 1234, write CTRL=0x3 -> count 0 next cycle and keeps counting;
//    write CTRL=0x0 -> value stable across 20 cycles.
//  4 [TIMER_CMP_EN] CMP=99, CTRL=0x5 -> irq rises when count==99, count returns to 0,
//    period 100 cycles; write STATUS=1 on same cycle as next match -> irq stays 1.
//  5 [TIMER_CMP_EN absent] write 0x55 to addr3, read addr3/5 -> 0; irq never asserts.
//  6 Assert reset while go=1 and irq=1 -> count, CTRL, shadow, irq all 0 within same cycle.

Source files
------------

// File: rtl/fpro_timer_core.sv
// fpro_timer_core: free-running up-counter occupying one FPro MMIO slot.
// A high-word shadow latch gives a coherent wide count read: reading CNT_LO
// captures the upper bits of the same count value, and CNT_HI returns them.
// Optional feature macro TIMER_CMP_EN adds a compare register, a sticky
// compare-match interrupt flag (W1C via STATUS) and periodic reload.
module fpro_timer_core #(
  parameter int CNT_W = 48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        irq
);

  localparam int HI_W = CNT_W - 32;

  logic             wr_en;
  logic             rd_en;
  logic             wr_ctrl;
  logic             match;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             go_reg;
  logic             reload_reg;
  logic [HI_W-1:0]  shadow_reg;
  logic             unused_bits;

  assign wr_en   = cs & write;
  assign rd_en   = cs & read;
  assign wr_ctrl = wr_en && (addr == 5'd2);

  // Upper write-data bits are only partly decoded; fold them into a sink.
  assign unused_bits = ^wr_data;

`ifdef TIMER_CMP_EN
  logic [CNT_W-1:0] cmp_reg;
  logic             irq_flag_reg;

  assign match = go_reg && (count_reg == cmp_reg);
  assign irq   = irq_flag_reg;

  // Compare register: low word at CMP_LO, remaining upper bits at CMP_HI.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp_reg <= '1;
    end else if (wr_en && (addr == 5'd3)) begin
      cmp_reg[31:0] <= wr_data;
    end else if (wr_en && (addr == 5'd4)) begin
      cmp_reg[CNT_W-1:32] <= wr_data[HI_W-1:0];
    end
  end

  // Sticky match flag; a match on the same edge as a W1C keeps it set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_flag_reg <= 1'b0;
    end else if (match) begin
      irq_flag_reg <= 1'b1;
    end else if (wr_en && (addr == 5'd5) && wr_data[0]) begin
      irq_flag_reg <= 1'b0;
    end
  end
`else
  assign match = 1'b0;
  assign irq   = 1'b0;
`endif

  // Next count: clear beats reload, reload beats increment.
  always_comb begin
    count_next = count_reg;
    if (wr_ctrl && wr_data[1]) begin
      count_next = '0;
    end else if (match && reload_reg) begin
      count_next = '0;
    end else if (go_reg) begin
      count_next = count_reg + CNT_W'(1);
    end
  end

  // Counter state and control bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg  <= '0;
      go_reg     <= 1'b0;
      reload_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (wr_ctrl) begin
        go_reg     <= wr_data[0];
        reload_reg <= wr_data[2];
      end
    end
  end

  // Shadow captures the upper count bits alongside each CNT_LO read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_reg <= '0;
    end else if (rd_en && (addr == 5'd0)) begin
      shadow_reg <= count_reg[CNT_W-1:32];
    end
  end

  // Combinational read mux, independent of the read strobe.
  always_comb begin
    rd_data = 32'd0;
    case (addr)
      5'd0: rd_data = count_reg[31:0];
      5'd1: rd_data = 32'(shadow_reg);
      5'd2: rd_data = {29'd0, reload_reg, 1'b0, go_reg};
`ifdef TIMER_CMP_EN
      5'd3: rd_data = cmp_reg[31:0];
      5'd4: rd_data = 32'(cmp_reg[CNT_W-1:32]);
      5'd5: rd_data = {31'd0, irq_flag_reg};
`endif
      default: rd_data = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_fpro_timer_core.sv
// Directed bench for fpro_timer_core (CNT_W=48). Inputs change on the falling
// edge; rd_data is sampled just after the drive, before the rising edge.
module tb_fpro_timer_core;

  logic        clk;
  logic        reset;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        irq;

  int checks;
  int fails;

  fpro_timer_core #(.CNT_W(48)) dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One bus write; returns on the following falling edge.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(negedge clk);
    cs = 1'b0; write = 1'b0; wr_data = 32'd0;
    $display("wr addr=%0d data=0x%08h", a, d);
  endtask

  // One bus read; data sampled before the edge on which the read is taken.
  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] v;
    cs = 1'b1; read = 1'b1; addr = a;
    #1 v = rd_data;
    @(negedge clk);
    cs = 1'b0; read = 1'b0;
    $display("rd addr=%0d data=0x%08h", a, v);
    check(tag, v, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    checks = 0; fails = 0;
    reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0;
    addr = 5'd0; wr_data = 32'd0;

    // Reset state, read combinationally while reset is held
    #2;
    addr = 5'd0; #1 check("rst_cnt_lo", rd_data, 32'd0);
    addr = 5'd1; #1 check("rst_shadow", rd_data, 32'd0);
    addr = 5'd2; #1 check("rst_ctrl", rd_data, 32'd0);
`ifdef TIMER_CMP_EN
    addr = 5'd3; #1 check("rst_cmp_lo", rd_data, 32'hFFFF_FFFF);
    addr = 5'd4; #1 check("rst_cmp_hi", rd_data, 32'h0000_FFFF);
`else
    addr = 5'd3; #1 check("rst_addr3", rd_data, 32'd0);
`endif
    check("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    addr = 5'd0;

    // 1: start counting, 10 cycles later the count is 10
    wr(5'd2, 32'h1);
    idle(10);
    rd_chk("t1_count10", 5'd0, 32'd10);
    check("t1_irq", {31'd0, irq}, 32'd0);

    // 2: coherent high-word read across the 32-bit boundary
    wr(5'd2, 32'h0);
    force dut.count_reg = 48'h0000_FFFF_FFFF;
    #1 release dut.count_reg;
    wr(5'd2, 32'h1);
    rd_chk("t2_lo_ffff", 5'd0, 32'hFFFF_FFFF);
    rd_chk("t2_hi_0", 5'd1, 32'h0000_0000);
    rd_chk("t2_lo_wrap", 5'd0, 32'h0000_0001);
    rd_chk("t2_hi_1", 5'd1, 32'h0000_0001);
    rd_chk("t2_ctrl", 5'd2, 32'h1);

    // 3: clear while running, then freeze
    wr(5'd2, 32'h3);
    rd_chk("t3_cleared", 5'd0, 32'd0);
    idle(4);
    rd_chk("t3_running", 5'd0, 32'd5);
    wr(5'd2, 32'h0);
    rd_chk("t3_frozen", 5'd0, 32'd7);
    idle(20);
    rd_chk("t3_still", 5'd0, 32'd7);
    rd_chk("t3_ctrl", 5'd2, 32'h0);

`ifdef TIMER_CMP_EN
    // 4: compare match with reload, period 100, set wins over W1C
    wr(5'd3, 32'd99);
    wr(5'd4, 32'hFFFF_FFFF);
    rd_chk("t4_cmp_hi_mask", 5'd4, 32'h0000_FFFF);
    wr(5'd4, 32'h0);
    rd_chk("t4_cmp_lo", 5'd3, 32'd99);
    wr(5'd2, 32'h7);
    rd_chk("t4_ctrl", 5'd2, 32'h5);
    idle(98);
    check("t4_irq_before", {31'd0, irq}, 32'd0);
    rd_chk("t4_count99", 5'd0, 32'd99);
    check("t4_irq_rise", {31'd0, irq}, 32'd1);
    rd_chk("t4_status", 5'd5, 32'd1);
    check("t4_status_sticky", {31'd0, irq}, 32'd1);
    rd_chk("t4_reloaded", 5'd0, 32'd1);
    idle(97);
    wr(5'd5, 32'h1);
    check("t4_set_wins", {31'd0, irq}, 32'd1);
    rd_chk("t4_reload2", 5'd0, 32'd0);
    wr(5'd5, 32'h1);
    check("t4_w1c", {31'd0, irq}, 32'd0);
    wr(5'd3, 32'd5);
    wr(5'd2, 32'h7);
    idle(6);
    check("t4_irq_again", {31'd0, irq}, 32'd1);
`else
    // 5: compare registers absent
    wr(5'd3, 32'h55);
    rd_chk("t5_addr3", 5'd3, 32'd0);
    rd_chk("t5_addr4", 5'd4, 32'd0);
    rd_chk("t5_addr5", 5'd5, 32'd0);
    rd_chk("t5_addr31", 5'd31, 32'd0);
    wr(5'd2, 32'h4);
    rd_chk("t5_reload_bit", 5'd2, 32'h4);
    cs = 1'b0; write = 1'b1; addr = 5'd2; wr_data = 32'h1;
    @(negedge clk);
    write = 1'b0; wr_data = 32'd0;
    rd_chk("t5_no_cs", 5'd2, 32'h4);
    check("t5_irq", {31'd0, irq}, 32'd0);
    wr(5'd2, 32'h1);
`endif

    // 6: asynchronous reset while running with nonzero shadow
    force dut.count_reg = 48'h0005_0000_0010;
    #1 release dut.count_reg;
    rd_chk("t6_lo", 5'd0, 32'h0000_0010);
    rd_chk("t6_shadow", 5'd1, 32'h0000_0005);
    reset = 1'b1;
    addr = 5'd0; #1 check("t6_cnt_rst", rd_data, 32'd0);
    addr = 5'd1; #1 check("t6_shadow_rst", rd_data, 32'd0);
    addr = 5'd2; #1 check("t6_ctrl_rst", rd_data, 32'd0);
    check("t6_irq_rst", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(3);
    addr = 5'd0; #1 check("t6_stopped", rd_data, 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
